distance_frame_sched: RTL and testbench
=======================================

Name: distance_frame_sched

Overview:
- Per-frame scheduler and sequencer for the distance estimate in the D8M vision pipeline.
- Captures the blob left/right bounds on each end-of-packet pulse. Computes distance with a multi-cycle serial divider instead of a combinational divide. Applies the range, width and centering checks.
- Presents one result per frame to the downstream message/UART builder over a valid/ready handshake.
- Drops and counts frames that arrive while a computation or delivery is still pending.

Parameters:
- IMAGE_W, 640, frame width in pixels.
- CALI_SIZE, 70, calibration object width in pixels at CALI_DIST.
- CALI_DIST, 30, calibration distance in cm.
- EDGE_MARGIN, 30, border margin; a blob touching both margins is rejected.
- MAX_WIDTH, 200, maximum accepted blob width in pixels.
- DIST_MIN, 15, minimum accepted distance.
- DIST_MAX, 55, maximum accepted distance.
- CTR_LO, 280, centered window lower bound (exclusive).
- CTR_HI, 360, centered window upper bound (exclusive).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- eop  in  1  one-cycle end-of-frame strobe; bounds are valid in that cycle.
- left_bound  in  11  blob left x pixel.
- right_bound  in  11  blob right x pixel.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  result available.
- out_distance  out  12  distance in cm, saturated to 4095.
- out_in_range  out  1  result passes all validity checks.
- out_centered  out  1  blob centre is inside (CTR_LO, CTR_HI).
- out_center_x  out  11  (left+right)>>1.
- busy  out  1  state != IDLE.
- overrun_cnt  out  8  saturating count of dropped eop strobes.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values: all outputs 0; state IDLE; internal registers 0.
- States: IDLE, CHECK, DIV, HOLD.
- IDLE:
  - On eop, latch the bounds.
  - Compute width = right-left in 12-bit signed arithmetic, and center = (left+right)>>1 using a 12-bit sum.
  - Go to CHECK.
- CHECK (1 cycle):
  - If width<=0: distance=4095, in_range=0, go to HOLD.
  - Otherwise load dividend NUM=CALI_SIZE*CALI_DIST (22-bit constant), divisor=width[10:0], clear the iteration counter, go to DIV.
- DIV:
  - Restoring divider, one quotient bit per cycle, 22 cycles MSB first.
  - After the last bit, saturate the quotient to 12 bits (any bit above 11 set -> 4095). Go to HOLD.
- Entering HOLD registers all result outputs and sets out_valid=1. The in_range and centered flags are computed as follows:
  - in_range = !(left<=EDGE_MARGIN && right>=IMAGE_W-EDGE_MARGIN) && width<=MAX_WIDTH && DIST_MIN<=dist<=DIST_MAX.
  - centered = center>CTR_LO && center<CTR_HI.
- HOLD:
  - Outputs stay stable while out_valid && !out_ready.
  - When out_valid && out_ready: clear out_valid, go to IDLE.
  - Result outputs keep their last value after the handshake.
- Latency (eop sampled at cycle 0):
  - width>0: out_valid=1 at cycle 24 (CHECK at 1, DIV at 2..23).
  - width<=0: out_valid=1 at cycle 2.
- Overrun: eop in any state other than IDLE is ignored and increments overrun_cnt. overrun_cnt saturates at 255.
- eop and a handshake completing in the same HOLD cycle: the eop is still counted as an overrun. The next frame is accepted only from IDLE.
- Asynchronous reset mid-DIV or mid-HOLD: immediate return to IDLE, all outputs 0. No partial result is emitted.

Optional Feature:
- Macro: DIST_AVG_EN.
- Enabled:
  - Holds a 4-entry history of raw quotients, pushed on each entry to HOLD.
  - The first push after reset fills all 4 entries.
  - out_distance = (sum of 4 entries)>>2, using a 14-bit sum.
  - The in_range distance test uses the averaged value.
  - The width<=0 path pushes nothing and reports 4095.
- Disabled: no history registers; out_distance is the raw saturated quotient.

Test Plan:
- Nominal: left=300, right=370, out_ready=1, eop -> cycle 24: out_valid=1, distance=30, in_range=1, centered=1, center_x=335; out_valid=0 at cycle 25.
- Zero/negative width: left=400, right=400, eop -> cycle 2: distance=4095, in_range=0, centered=0, center_x=400.
- Reject and saturation:
  - left=10, right=635 -> in_range=0 (edge rule), distance=3.
  - left=100, right=101 -> distance=2100, in_range=0.
- Backpressure and overrun: out_ready=0 for 50 cycles after a nominal result; 3 eop strobes during DIV/HOLD -> outputs stable, overrun_cnt=3; next eop after the handshake is accepted.
- Reset mid-DIV: reset_n low at cycle 10 after eop -> all outputs 0 immediately, no out_valid; a fresh eop afterwards completes in 24 cycles.
- DIST_AVG_EN: first frame width 70 (q=30), second frame width 35 (q=60) -> first average 30, second average (30*3+60)/4=37.

Source files
------------

// File: rtl/distance_frame_sched.sv
// rtl/distance_frame_sched.sv - per-frame blob distance scheduler with a serial restoring divider
// Optional DIST_AVG_EN: report the mean of the last four quotients instead of the raw one.
module distance_frame_sched #(
  parameter int IMAGE_W     = 640,
  parameter int CALI_SIZE   = 70,
  parameter int CALI_DIST   = 30,
  parameter int EDGE_MARGIN = 30,
  parameter int MAX_WIDTH   = 200,
  parameter int DIST_MIN    = 15,
  parameter int DIST_MAX    = 55,
  parameter int CTR_LO      = 280,
  parameter int CTR_HI      = 360
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        eop,
  input  logic [10:0] left_bound,
  input  logic [10:0] right_bound,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [11:0] out_distance,
  output logic        out_in_range,
  output logic        out_centered,
  output logic [10:0] out_center_x,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_HOLD} state_t;

  localparam logic [21:0]        NUM       = 22'(CALI_SIZE * CALI_DIST);
  localparam logic [10:0]        EDGE_LO   = 11'(EDGE_MARGIN);
  localparam logic [10:0]        EDGE_HI   = 11'(IMAGE_W - EDGE_MARGIN);
  localparam logic signed [11:0] WIDTH_MAX = 12'(MAX_WIDTH);
  localparam logic [11:0]        D_MIN     = 12'(DIST_MIN);
  localparam logic [11:0]        D_MAX     = 12'(DIST_MAX);
  localparam logic [10:0]        C_LO      = 11'(CTR_LO);
  localparam logic [10:0]        C_HI      = 11'(CTR_HI);
  localparam logic [4:0]         LAST_ITER = 5'd21;

  state_t             state, state_nxt;
  logic [10:0]        left_q, right_q, center_q, dvsr_q, rem_q;
  logic signed [11:0] width_q, width_c;
  logic [10:0]        center_c;
  logic [21:0]        dvd_q, dvd_nxt;
  logic [11:0]        rem_sh;
  logic [10:0]        rem_nxt;
  logic               q_bit;
  logic [4:0]         iter_q;
  logic               last_step, zero_width, handshake;
  logic [11:0]        quo_sat, dist_res;
  logic               range_ok, centered_c;

  always_comb begin
    width_c  = $signed({1'b0, right_bound}) - $signed({1'b0, left_bound});
    center_c = 11'(({1'b0, left_bound} + {1'b0, right_bound}) >> 1);
  end

  // Dividend register shifts out MSB-first while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[21]};
    q_bit   = (rem_sh >= {1'b0, dvsr_q});
    rem_nxt = q_bit ? 11'(rem_sh - {1'b0, dvsr_q}) : rem_sh[10:0];
    dvd_nxt = {dvd_q[20:0], q_bit};
    quo_sat = (|dvd_nxt[21:12]) ? 12'hFFF : dvd_nxt[11:0];
  end

  assign last_step  = (state == S_DIV) && (iter_q == LAST_ITER);
  assign zero_width = (state == S_CHECK) && (width_q <= 12'sd0);
  assign handshake  = (state == S_HOLD) && out_valid && out_ready;
  assign centered_c = (center_q > C_LO) && (center_q < C_HI);
  assign range_ok   = !((left_q <= EDGE_LO) && (right_q >= EDGE_HI))
                      && (width_q <= WIDTH_MAX)
                      && (dist_res >= D_MIN) && (dist_res <= D_MAX);

`ifdef DIST_AVG_EN
  // The newest of the four entries is the quotient being pushed; these hold the three older ones.
  logic [11:0] hist_q [3];
  logic        hist_vld_q;
  logic [13:0] hist_sum;

  always_comb begin
    if (hist_vld_q)
      hist_sum = 14'(quo_sat) + 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]);
    else
      hist_sum = {quo_sat, 2'b00};
    dist_res = hist_sum[13:2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) hist_q[i] <= '0;
      hist_vld_q <= 1'b0;
    end else if (last_step) begin
      hist_vld_q <= 1'b1;
      hist_q[0]  <= quo_sat;
      for (int i = 1; i < 3; i++) hist_q[i] <= hist_vld_q ? hist_q[i-1] : quo_sat;
    end
  end
`else
  assign dist_res = quo_sat;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (eop) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (width_q <= 12'sd0) ? S_HOLD : S_DIV;
      S_DIV:   if (iter_q == LAST_ITER) state_nxt = S_HOLD;
      S_HOLD:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q   <= '0;
      right_q  <= '0;
      width_q  <= '0;
      center_q <= '0;
      dvd_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (eop) begin
          left_q   <= left_bound;
          right_q  <= right_bound;
          width_q  <= width_c;
          center_q <= center_c;
        end
        S_CHECK: begin
          dvd_q  <= NUM;
          dvsr_q <= width_q[10:0];
          rem_q  <= '0;
          iter_q <= '0;
        end
        S_DIV: begin
          dvd_q  <= dvd_nxt;
          rem_q  <= rem_nxt;
          iter_q <= iter_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // An eop in any busy state is dropped, including one coinciding with the HOLD handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overrun_cnt <= '0;
    else if (eop && (state != S_IDLE) && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_distance <= '0;
      out_in_range <= 1'b0;
      out_centered <= 1'b0;
      out_center_x <= '0;
    end else if (zero_width) begin
      out_valid    <= 1'b1;
      out_distance <= 12'hFFF;
      out_in_range <= 1'b0;
      out_centered <= centered_c;
      out_center_x <= center_q;
    end else if (last_step) begin
      out_valid    <= 1'b1;
      out_distance <= dist_res;
      out_in_range <= range_ok;
      out_centered <= centered_c;
      out_center_x <= center_q;
    end else if (handshake) begin
      out_valid    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_distance_frame_sched.sv
// tb/tb_distance_frame_sched.sv - randomized self-checking bench for distance_frame_sched
// Compile with +define+DIST_AVG_EN to check the averaging build.
module tb_distance_frame_sched;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        eop = 1'b0;
  logic [10:0] left_bound = '0;
  logic [10:0] right_bound = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [11:0] out_distance;
  logic        out_in_range;
  logic        out_centered;
  logic [10:0] out_center_x;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int m_ovr = 0;
  int hist[$];

  always #5 clk = ~clk;

  distance_frame_sched dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .eop          (eop),
    .left_bound   (left_bound),
    .right_bound  (right_bound),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_distance (out_distance),
    .out_in_range (out_in_range),
    .out_centered (out_centered),
    .out_center_x (out_center_x),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic note_ovr();
    if (m_ovr < 255) m_ovr++;
  endtask

  // Reference: distance = CALI_SIZE*CALI_DIST / width, averaged over the last four when enabled.
  task automatic model(input int l, input int r, output int lat, output int d,
                       output int inr, output int ctr, output int cx);
    int w, q, s;
    w   = r - l;
    cx  = (l + r) / 2;
    ctr = (cx > 280 && cx < 360) ? 1 : 0;
    if (w <= 0) begin
      lat = 2; d = 4095; inr = 0;
    end else begin
      lat = 24;
      q = 2100 / w;
      if (q > 4095) q = 4095;
`ifdef DIST_AVG_EN
      if (hist.size() == 0) begin
        repeat (4) hist.push_back(q);
      end else begin
        hist.push_front(q);
        void'(hist.pop_back());
      end
      s = 0;
      foreach (hist[i]) s += hist[i];
      d = s / 4;
`else
      s = 0;
      d = q;
`endif
      inr = (!(l <= 30 && r >= 610) && w <= 200 && d >= 15 && d <= 55) ? 1 : 0;
    end
  endtask

  task automatic do_frame(input int l, input int r, input int stall, input int dups,
                          input int hold_eops, input bit eop_on_release);
    int n, lat, d, inr, ctr, cx, diffs;
    logic [11:0] s_d;
    logic [10:0] s_cx;
    logic s_r, s_c;
    model(l, r, lat, d, inr, ctr, cx);
    out_ready   = (stall == 0);
    left_bound  = 11'(l);
    right_bound = 11'(r);
    eop = 1'b1;
    step();
    eop = 1'b0;
    n = 1;
    left_bound  = 11'($urandom);
    right_bound = 11'($urandom);
    while (!out_valid && n < 100) begin
      eop = (n >= 3 && n < 3 + dups);
      step();
      if (eop) note_ovr();
      eop = 1'b0;
      n++;
    end
    check("latency", n, lat);
    check("valid", out_valid, 1);
    check("busy", busy, 1);
    check("distance", out_distance, d);
    check("in_range", out_in_range, inr);
    check("centered", out_centered, ctr);
    check("center_x", out_center_x, cx);
    s_d = out_distance; s_cx = out_center_x; s_r = out_in_range; s_c = out_centered;
    diffs = 0;
    for (int i = 0; i < stall; i++) begin
      eop = (i < hold_eops);
      step();
      if (eop) note_ovr();
      eop = 1'b0;
      if (!out_valid || out_distance != s_d || out_center_x != s_cx ||
          out_in_range != s_r || out_centered != s_c) diffs++;
    end
    if (stall > 0) check("hold_stable", diffs, 0);
    check("overrun_cnt", overrun_cnt, m_ovr);
    out_ready = 1'b1;
    eop = eop_on_release;
    step();
    if (eop) note_ovr();
    eop = 1'b0;
    check("valid_clear", out_valid, 0);
    check("idle", busy, 0);
    check("overrun_after", overrun_cnt, m_ovr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_distance"}, out_distance, 0);
    check({tag, "_in_range"}, out_in_range, 0);
    check({tag, "_centered"}, out_centered, 0);
    check({tag, "_center_x"}, out_center_x, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun_cnt, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_ovr = 0;
    hist.delete();
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  initial begin
    int l, r, n, cnt;
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    do_frame(300, 370, 0, 0, 0, 0);
    do_frame(400, 400, 0, 0, 0, 0);
    do_frame(10, 635, 0, 0, 0, 0);
    do_frame(100, 101, 0, 0, 0, 0);
    do_frame(350, 300, 0, 0, 0, 0);

    do_frame(300, 370, 50, 2, 1, 1);
    do_frame(300, 370, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      l = int'($urandom_range(0, 660));
      if ($urandom_range(0, 1) == 0) r = l + int'($urandom_range(1, 150));
      else r = int'($urandom_range(0, 700));
      do_frame(l, r, int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 1 : 0, 0, ($urandom_range(0, 4) == 0));
    end

    do_frame(300, 370, 270, 0, 260, 0);
    check("overrun_sat", overrun_cnt, 255);

    out_ready   = 1'b0;
    left_bound  = 11'd350;
    right_bound = 11'd420;
    eop = 1'b1;
    step();
    eop = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin step(); n++; end
    check("hold_before_reset", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_hold");
    do_reset();

    out_ready   = 1'b1;
    left_bound  = 11'd300;
    right_bound = 11'd370;
    eop = 1'b1;
    step();
    eop = 1'b0;
    left_bound  = 11'd300;
    right_bound = 11'd335;
    eop = 1'b1;
    step();
    eop = 1'b0;
    note_ovr();
    repeat (8) step();
    check("busy_mid_div", busy, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_div");
    do_reset();
    cnt = 0;
    repeat (30) begin
      step();
      if (out_valid) cnt++;
    end
    check("no_valid_after_reset", cnt, 0);

    do_frame(300, 370, 0, 0, 0, 0);
    do_frame(300, 335, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end
endmodule
